uart_rx_ex: RTL and testbench

UART_RX_EX -- requirements
Module: uart_rx_ex

---
 rtl/uart_rx_ex.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_ex.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ex.sv
// uart_rx_ex: oversampling UART receiver (5..9 data bits, optional even/odd parity, 1 or 2 stop bits).
// Optional macro UART_RX_MAJORITY_EN: each bit becomes a 2-of-3 vote over the last three line samples.
module uart_rx_ex #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic                 rx,
    input  logic [31:0]          clk_count_bit,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bits,
    output logic [DATA_BITS-1:0] data,
    output logic                 end_flag,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [1:0]           sync_q;
    logic [3:0]           hist_q, hist_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [3:0]           bitn_q, bitn_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
    logic [1:0]           pm_q, pm_d;
    logic                 sb_q, sb_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                 perr_o_q, perr_o_d, ferr_o_q, ferr_o_d, end_q, end_d;
    logic                 line, smp, tick, par_en, par_x, fin;
    logic [31:0]          start_tgt;

    assign line = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) maj_q <= 2'b11;
        else     maj_q <= {maj_q[0], line};
    end
    // maj_q holds the line at target-2 and target-1 when the counter reaches target.
    assign smp = (maj_q[1] & maj_q[0]) | (maj_q[1] & line) | (maj_q[0] & line);
`else
    assign smp = line;
`endif

    assign start_tgt = (clk_count_bit >> 1) - 32'd4;
    assign tick      = (cnt_q == clk_count_bit - 32'd1);
    assign par_en    = (pm_q == 2'b01) || (pm_q == 2'b10);
    assign par_x     = (^shreg_q) ^ smp;

    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        cnt_d    = cnt_q + 32'd1;
        bitn_d   = bitn_q;
        shreg_d  = shreg_q;
        pm_d     = pm_q;
        sb_d     = sb_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        data_d   = data_q;
        perr_o_d = perr_o_q;
        ferr_o_d = ferr_o_q;
        end_d    = 1'b0;
        fin      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                hist_d = {hist_q[2:0], line};
                if (hist_q == 4'b0000 && rx_en) begin
                    state_d = START;
                    bitn_d  = '0;
                    pm_d    = parity_mode;
                    sb_d    = stop_bits;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            START: if (cnt_q == start_tgt) begin
                cnt_d = '0;
                // A high start sample is a glitch; re-arm the history so detection restarts cleanly.
                if (smp) begin
                    state_d = IDLE;
                    hist_d  = 4'hF;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: if (tick) begin
                cnt_d   = '0;
                shreg_d = {smp, shreg_q[DATA_BITS-1:1]};
                bitn_d  = bitn_q + 4'd1;
                if (bitn_q == LAST_BIT) state_d = par_en ? PARITY : STOP1;
            end
            PARITY: if (tick) begin
                cnt_d   = '0;
                perr_d  = (pm_q == 2'b01) ? par_x : ~par_x;
                state_d = STOP1;
            end
            STOP1: if (tick) begin
                cnt_d  = '0;
                ferr_d = ferr_q | ~smp;
                if (sb_q) state_d = STOP2;
                else      fin = 1'b1;
            end
            STOP2: if (tick) begin
                cnt_d = '0;
                fin   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (fin) begin
            state_d  = IDLE;
            hist_d   = 4'hF;
            data_d   = shreg_q;
            perr_o_d = perr_q;
            ferr_o_d = ferr_q | ~smp;
            end_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sync_q   <= 2'b11;
            hist_q   <= 4'hF;
            cnt_q    <= '0;
            bitn_q   <= '0;
            shreg_q  <= '0;
            pm_q     <= '0;
            sb_q     <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            data_q   <= '0;
            perr_o_q <= 1'b0;
            ferr_o_q <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[0], rx};
            hist_q   <= hist_d;
            cnt_q    <= cnt_d;
            bitn_q   <= bitn_d;
            shreg_q  <= shreg_d;
            pm_q     <= pm_d;
            sb_q     <= sb_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            data_q   <= data_d;
            perr_o_q <= perr_o_d;
            ferr_o_q <= ferr_o_d;
            end_q    <= end_d;
        end
    end

    assign data       = data_q;
    assign end_flag   = end_q;
    assign parity_err = perr_o_q;
    assign frame_err  = ferr_o_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_ex.sv
// Bench for uart_rx_ex: serial frames are driven bit by bit; expected {data, parity_err, frame_err}
// words are queued when a frame is issued and a monitor compares them on every end_flag.
module tb_uart_rx_ex;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx_en;
    logic        rx;
    logic [31:0] clk_count_bit;
    logic [1:0]  parity_mode;
    logic        stop_bits;
    logic [7:0]  data;
    logic        end_flag, parity_err, frame_err, busy;

    int          checks = 0;
    int          failures = 0;
    int          cbit;
    logic [7:0]  last_data = 8'h00;
    logic [9:0]  exp_q[$];

    uart_rx_ex #(.DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx(rx), .clk_count_bit(clk_count_bit),
        .parity_mode(parity_mode), .stop_bits(stop_bits), .data(data), .end_flag(end_flag),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every end_flag must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && end_flag) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_end_flag actual data=%0h pe=%0b fe=%0b expected no frame", data, parity_err, frame_err);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({data, parity_err, frame_err} !== e) begin
                    failures++;
                    $display("FAIL frame actual data=%0h pe=%0b fe=%0b expected data=%0h pe=%0b fe=%0b",
                             data, parity_err, frame_err, e[9:2], e[1], e[0]);
                end
            end
            check("busy_at_end", {31'd0, busy}, 32'd0);
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bit cell; the optional glitch lands exactly on the receiver's sample point.
    task automatic drive_bit(input logic b, input logic glitch);
        for (int j = 0; j < cbit; j++) begin
            rx = (glitch && j == cbit / 2 + 1) ? ~b : b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            cycles(1);
            n++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic sb,
                              input logic pbit, input logic s1_low, input logic s2_low,
                              input int gbit, input logic en_drop, input logic expect_it);
        logic [7:0] rd;
        logic       pe, fe;
        int         ones;
`ifdef UART_RX_MAJORITY_EN
        rd = d;
`else
        rd = (gbit >= 0 && gbit < 8) ? d ^ (8'd1 << gbit) : d;
`endif
        ones = $countones({rd, pbit});
        pe = (pm == 2'b01) ? (ones % 2 == 1) : (pm == 2'b10) ? (ones % 2 == 0) : 1'b0;
        fe = s1_low | (sb & s2_low);
        if (expect_it) begin
            exp_q.push_back({rd, pe, fe});
            last_data = rd;
        end
        parity_mode = pm;
        stop_bits   = sb;
        drive_bit(1'b0, 1'b0);
        if (en_drop) rx_en = 1'b0;
        for (int i = 0; i < 8; i++) drive_bit(d[i], i == gbit);
        if (pm == 2'b01 || pm == 2'b10) drive_bit(pbit, 1'b0);
        drive_bit(~s1_low, 1'b0);
        if (sb) drive_bit(~s2_low, 1'b0);
        rx = 1'b1;
        if (en_drop) rx_en = 1'b1;
        cycles(2 * cbit);
        wait_idle();
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; rx_en = 1'b1; cbit = 100; clk_count_bit = 32'd100;
        parity_mode = 2'b00; stop_bits = 1'b0;
        cycles(3);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_end_flag", {31'd0, end_flag}, 32'd0);
        check("rst_parity_err", {31'd0, parity_err}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        cycles(10);

        send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1);
        send_frame(8'h07, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1);
        send_frame(8'h07, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b1);
        send_frame(8'h3C, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1);
        send_frame(8'h5A, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b1);

        // Short low pulse: a false start that must leave the outputs alone.
        rx = 1'b0;
        cycles(10);
        rx = 1'b1;
        cycles(150);
        check("false_start_busy", {31'd0, busy}, 32'd0);
        check("false_start_data", {24'd0, data}, {24'd0, last_data});

        // Reset in the middle of 0xFF after its fourth data bit.
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
        rst = 1'b1;
        cycles(2);
        check("midrst_data", {24'd0, data}, 32'd0);
        check("midrst_end_flag", {31'd0, end_flag}, 32'd0);
        check("midrst_parity_err", {31'd0, parity_err}, 32'd0);
        check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        cycles(10);
        send_frame(8'h12, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1);

        send_frame(8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1);

        // Receiver disabled: the frame is ignored.
        rx_en = 1'b0;
        send_frame(8'h99, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        rx_en = 1'b1;
        cycles(10);
        check("disabled_data", {24'd0, data}, {24'd0, last_data});

        for (int k = 0; k < 30; k++) begin
            cbit = $urandom_range(16, 40);
            clk_count_bit = cbit;
            cycles(5);
            send_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                       $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, -1,
                       1'($urandom), 1'b1);
        end

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 5000) begin
                cycles(1);
                n++;
            end
            check("pending_frames", exp_q.size(), 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
